// File: rtl/dmem_wbuf_ctrl_if.sv
// Data-memory bus between the write-buffer controller (master) and the memory port (slave).
`timescale 1ns/1ps
interface dmem_wbuf_ctrl_if;
  // Handshake: the master raises bus_req with bus_we/bus_addr/bus_wdata already valid and
  // holds all of them unchanged until the slave pulses bus_ack for exactly one cycle;
  // bus_rdata is only meaningful in that cycle, and the master drops bus_req on the same edge.
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_wbuf_ctrl.sv
// Data-memory controller: posted-store write buffer with load forwarding, and a
// single-master bus FSM that drains stores and services load misses.
`timescale 1ns/1ps
module dmem_wbuf_ctrl #(
  parameter int WB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dReadMem,
  input  logic                       dWriteMem,
  input  logic [31:0]                dAddr,
  input  logic [31:0]                wData,
  output logic [31:0]                rData,
  output logic                       Enable,
  dmem_wbuf_ctrl_if.master           bus,
  output logic [1:0]                 dbgState,
  output logic [$clog2(WB_DEPTH):0]  dbgCount
);

  localparam int PW = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DONE = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t        state;
  logic [29:0]   wbAddr [WB_DEPTH];
  logic [31:0]   wbData [WB_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [31:0]   rdQ;

  logic        hit;
  logic [31:0] hitData;
  logic        isLoad;
  logic        isStore;
  logic        storeStall;
  logic        loadMiss;
  logic        push;
  logic        pop;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^dAddr[1:0];

  // Walk from oldest to newest so the last match wins; the head entry still matches
  // in the cycle it is being popped because count only drops at the edge.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (((PW+1)'(i) < count) && (wbAddr[head + PW'(i)] == dAddr[31:2])) begin
        hit     = 1'b1;
        hitData = wbData[head + PW'(i)];
      end
    end
  end

  assign isLoad     = dReadMem;
  assign isStore    = dWriteMem && !dReadMem;
  assign storeStall = isStore && (count == (PW+1)'(WB_DEPTH));
  assign loadMiss   = isLoad && !hit && (state != RD_DONE);
  assign Enable     = !(storeStall || loadMiss);
  assign push       = isStore && Enable;
  assign pop        = (state == WR_REQ) && bus.bus_ack;

  always_comb begin
    rData = '0;
    if (state == RD_DONE) begin
      rData = rdQ;
    end else if (isLoad && hit) begin
      rData = hitData;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wbAddr[tail] <= dAddr[31:2];
      wbData[tail] <= wData;
    end
  end

  // Miss arbitration happens only in IDLE, so an in-flight write always finishes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      rdQ           <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

      case (state)
        IDLE: begin
          if (isLoad && !hit) begin
            state         <= RD_REQ;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= {dAddr[31:2], 2'b00};
            bus.bus_wdata <= '0;
          end else if (count != '0) begin
            state         <= WR_REQ;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= 1'b1;
            bus.bus_addr  <= {wbAddr[head], 2'b00};
            bus.bus_wdata <= wbData[head];
          end
        end
        RD_REQ: begin
          if (bus.bus_ack) begin
            rdQ         <= bus.bus_rdata;
            bus.bus_req <= 1'b0;
            state       <= RD_DONE;
          end
        end
        RD_DONE: begin
          state <= IDLE;
        end
        WR_REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbgState = state;
  assign dbgCount = count;

endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
// Bench for dmem_wbuf_ctrl: directed scenarios plus random load/store traffic against an
// architectural memory image, a pending-store queue and a latency-programmable bus memory.
`timescale 1ns/1ps
module tb_dmem_wbuf_ctrl;

  localparam int WB_DEPTH = 4;
  localparam int OP_LIMIT = 100;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        dReadMem;
  logic        dWriteMem;
  logic [31:0] dAddr;
  logic [31:0] wData;
  logic [31:0] rData;
  logic        Enable;
  logic [1:0]  dbgState;
  logic [2:0]  dbgCount;

  dmem_wbuf_ctrl_if bus();

  dmem_wbuf_ctrl #(.WB_DEPTH(WB_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .dReadMem (dReadMem),
    .dWriteMem(dWriteMem),
    .dAddr    (dAddr),
    .wData    (wData),
    .rData    (rData),
    .Enable   (Enable),
    .bus      (bus),
    .dbgState (dbgState),
    .dbgCount (dbgCount)
  );

  // reference model state
  logic [31:0] archMem [logic [29:0]];
  logic [31:0] physMem [logic [29:0]];
  ent_t        pendQ[$];
  logic        ackLog[$];

  int          nChecks = 0;
  int          nFail   = 0;
  int          nReads  = 0;
  int          waitCnt = 0;
  int          memLat  = 1;
  logic        respOn  = 1'b0;
  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic        prevWe  = 1'b0;
  logic [31:0] prevAddr  = '0;
  logic [31:0] prevWdata = '0;

  function automatic logic [31:0] initVal(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] memRead(input logic [29:0] a);
    if (physMem.exists(a)) return physMem[a];
    return initVal(a);
  endfunction

  function automatic logic [31:0] archRead(input logic [29:0] a);
    if (archMem.exists(a)) return archMem[a];
    return initVal(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus memory: acks after memLat cycles of bus_req, checks payload stability and FIFO order.
  task automatic resp();
    ent_t e;
    check("wb_count", 32'(dbgCount), 32'(pendQ.size()));
    if (prevReq && !prevAck && bus.bus_req) begin
      check("hold_addr", bus.bus_addr, prevAddr);
      check("hold_wdata", bus.bus_wdata, prevWdata);
      check("hold_we", 32'(bus.bus_we), 32'(prevWe));
    end
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h0BAD_0BAD;
    if (!bus.bus_req) begin
      waitCnt = 0;
    end else if (respOn) begin
      waitCnt++;
      if (waitCnt >= memLat) begin
        waitCnt     = 0;
        bus.bus_ack = 1'b1;
        ackLog.push_back(bus.bus_we);
        if (bus.bus_we) begin
          check("wr_pending", 32'(pendQ.size() != 0), 32'd1);
          if (pendQ.size() != 0) begin
            e = pendQ.pop_front();
            check("wr_addr", bus.bus_addr, {e.a, 2'b00});
            check("wr_data", bus.bus_wdata, e.d);
          end
          physMem[bus.bus_addr[31:2]] = bus.bus_wdata;
        end else begin
          bus.bus_rdata = memRead(bus.bus_addr[31:2]);
          nReads++;
        end
      end
    end
    prevReq   = bus.bus_req;
    prevAck   = bus.bus_ack;
    prevWe    = bus.bus_we;
    prevAddr  = bus.bus_addr;
    prevWdata = bus.bus_wdata;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      dReadMem  = 1'b0;
      dWriteMem = 1'b0;
      resp();
      #1;
      check("idle_rdata", rData, 32'd0);
      check("idle_enable", 32'(Enable), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Present one request until the pipeline advances; every load is checked for data and
  // for zero-latency exactly when a pending store holds the word.
  task automatic doOp(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output int stalls, output logic [31:0] rv);
    logic done;
    logic hit;
    ent_t e;
    hit = 1'b0;
    foreach (pendQ[i]) if (pendQ[i].a == a[31:2]) hit = 1'b1;
    dReadMem  = rd;
    dWriteMem = wr;
    dAddr     = a;
    wData     = d;
    stalls    = 0;
    rv        = '0;
    done      = 1'b0;
    for (int k = 0; k < OP_LIMIT && !done; k++) begin
      resp();
      #1;
      if (Enable) begin
        done = 1'b1;
        rv   = rData;
      end else begin
        stalls++;
      end
      @(posedge clk);
      if (done && wr && !rd) begin
        e.a = a[31:2];
        e.d = d;
        pendQ.push_back(e);
        archMem[a[31:2]] = d;
      end
      @(negedge clk);
    end
    dReadMem  = 1'b0;
    dWriteMem = 1'b0;
    check("op_done", 32'(done), 32'd1);
    if (done && rd) begin
      check("load_data", rv, archRead(a[31:2]));
      check("load_zero_latency_iff_hit", 32'(stalls == 0), 32'(hit));
    end
  endtask

  task automatic drain();
    logic ok;
    ok     = 1'b0;
    respOn = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (pendQ.size() == 0 && !bus.bus_req) ok = 1'b1;
      else idle(1);
    end
    check("drain_done", 32'(ok), 32'd1);
  endtask

  initial begin
    int          st;
    logic [31:0] rv;
    int          rdBefore;
    ent_t        e;
    logic [31:0] a;
    logic [31:0] d;
    int          op;

    // reset
    rst = 1'b1;
    dReadMem = 1'b0; dWriteMem = 1'b0; dAddr = '0; wData = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    @(negedge clk);
    #1;
    check("rst_bus_req", 32'(bus.bus_req), 32'd0);
    check("rst_bus_we", 32'(bus.bus_we), 32'd0);
    check("rst_bus_addr", bus.bus_addr, 32'd0);
    check("rst_bus_wdata", bus.bus_wdata, 32'd0);
    check("rst_count", 32'(dbgCount), 32'd0);
    check("rst_enable", 32'(Enable), 32'd1);
    check("rst_rdata", rData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // store then immediate load of the same word: forwarded, no bus read
    respOn = 1'b0;
    rdBefore = nReads;
    doOp(1'b0, 1'b1, 32'h100, 32'hAAAA_0001, st, rv);
    check("fwd_store_stalls", st, 0);
    doOp(1'b1, 1'b0, 32'h100, 32'h0, st, rv);
    check("fwd_rdata", rv, 32'hAAAA_0001);
    check("fwd_stalls", st, 0);
    check("fwd_no_bus_read", nReads, rdBefore);
    drain();

    // two stores to one word, load with low bits set returns the newest
    respOn = 1'b0;
    doOp(1'b0, 1'b1, 32'h100, 32'h11, st, rv);
    doOp(1'b0, 1'b1, 32'h100, 32'h22, st, rv);
    doOp(1'b1, 1'b0, 32'h102, 32'h0, st, rv);
    check("newest_rdata", rv, 32'h22);
    drain();

    // load miss with a 3-cycle bus response
    physMem[30'h80] = 32'hDEAD_BEEF;
    archMem[30'h80] = 32'hDEAD_BEEF;
    memLat = 3;
    rdBefore = nReads;
    doOp(1'b1, 1'b0, 32'h200, 32'h0, st, rv);
    check("miss_stall_cycles", st, 4);
    check("miss_rdata", rv, 32'hDEAD_BEEF);
    check("miss_one_read", nReads, rdBefore + 1);
    idle(1);

    // fill the buffer with the bus stalled; the fifth store waits for a pop plus one cycle
    respOn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      doOp(1'b0, 1'b1, 32'h300 + 32'(i) * 4, 32'h3000_0000 + 32'(i), st, rv);
      check("fill_no_stall", st, 0);
    end
    dWriteMem = 1'b1; dAddr = 32'h310; wData = 32'h3000_0004;
    for (int k = 0; k < 2; k++) begin
      resp();
      #1;
      check("full_stall", 32'(Enable), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    respOn = 1'b1; memLat = 1;
    resp();
    #1;
    check("full_stall_at_ack", 32'(Enable), 32'd0);
    respOn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp();
    #1;
    check("slot_free_enable", 32'(Enable), 32'd1);
    @(posedge clk);
    e.a = 30'(32'h310 >> 2);
    e.d = 32'h3000_0004;
    pendQ.push_back(e);
    archMem[e.a] = e.d;
    @(negedge clk);
    dWriteMem = 1'b0;
    #1;
    check("count_after_fill", 32'(dbgCount), 32'd4);
    drain();

    // load miss while a write is on the bus: write completes first
    respOn = 1'b0;
    doOp(1'b0, 1'b1, 32'h400, 32'h55, st, rv);
    idle(1);
    check("wr_pending_we", 32'(bus.bus_we), 32'd1);
    ackLog.delete();
    respOn = 1'b1; memLat = 2;
    doOp(1'b1, 1'b0, 32'h500, 32'h0, st, rv);
    check("order_stalls", st, 5);
    check("order_ack_count", 32'(ackLog.size()), 32'd2);
    if (ackLog.size() == 2) begin
      check("order_first_is_write", 32'(ackLog[0]), 32'd1);
      check("order_second_is_read", 32'(ackLog[1]), 32'd0);
    end
    idle(1);

    // reset during a read; a late ack must not be taken
    respOn = 1'b0;
    dReadMem = 1'b1; dAddr = 32'h600;
    resp();
    #1;
    check("rst_miss_stall", 32'(Enable), 32'd0);
    @(posedge clk);
    @(negedge clk);
    resp();
    #1;
    check("rdreq_bus_req", 32'(bus.bus_req), 32'd1);
    check("rdreq_bus_we", 32'(bus.bus_we), 32'd0);
    check("rdreq_bus_addr", bus.bus_addr, 32'h600);
    rst = 1'b1; dReadMem = 1'b0;
    #1;
    check("midrst_bus_req", 32'(bus.bus_req), 32'd0);
    check("midrst_enable", 32'(Enable), 32'd1);
    check("midrst_count", 32'(dbgCount), 32'd0);
    check("midrst_bus_addr", bus.bus_addr, 32'd0);
    pendQ.delete(); prevReq = 1'b0; waitCnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hBAD0_0001;
    #1;
    check("late_ack_bus_req", 32'(bus.bus_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.bus_ack = 1'b0;
    prevReq = 1'b0;
    idle(2);
    respOn = 1'b1; memLat = 2;
    doOp(1'b1, 1'b0, 32'h600, 32'h0, st, rv);
    check("post_rst_miss_stalls", st, 3);
    idle(1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      memLat = $urandom_range(1, 4);
      op = $urandom_range(0, 9);
      a = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      if (op <= 3)      doOp(1'b1, 1'b0, a, d, st, rv);
      else if (op <= 7) doOp(1'b0, 1'b1, a, d, st, rv);
      else if (op == 8) doOp(1'b1, 1'b1, a, d, st, rv);
      else              idle(1);
    end
    drain();

    foreach (archMem[k]) check("mem_image", memRead(k), archMem[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
